// File: rtl/windowed_energy_mc_pkg.sv
// energy_pkg: shared constants, clog2 and the result record of the windowed energy detector.
package energy_pkg;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int acc_w(input int data_w, input int window);
        return 2 * data_w + clog2(window);
    endfunction
    localparam int DEF_DATA_W = 16;
    localparam int DEF_WINDOW = 16;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CH_W = (clog2(DEF_NUM_CH) > 1) ? clog2(DEF_NUM_CH) : 1;
    localparam int DEF_ACC_W = acc_w(DEF_DATA_W, DEF_WINDOW);
    typedef struct packed {
        logic [DEF_CH_W-1:0]  ch;
        logic [DEF_ACC_W-1:0] energy;
        logic                 full;
    } energy_res_t;
endpackage

// File: rtl/windowed_energy_mc_if.sv
// windowed_energy_mc_if: sample in / energy out bus; thresh and out_above exist only with ENERGY_THRESH_EN.
interface windowed_energy_mc_if #(parameter int DATA_W = 16, parameter int CH_W = 2, parameter int ACC_W = 36);
    logic                     flush;
    logic                     in_valid;
    logic [CH_W-1:0]          in_ch;
    logic signed [DATA_W-1:0] in_sample;
    logic                     out_valid;
    logic [CH_W-1:0]          out_ch;
    logic [ACC_W-1:0]         out_energy;
    logic                     out_full;
`ifdef ENERGY_THRESH_EN
    logic [ACC_W-1:0]         thresh;
    logic                     out_above;
`endif
    modport master (
`ifdef ENERGY_THRESH_EN
        output thresh, input out_above,
`endif
        output flush, in_valid, in_ch, in_sample,
        input out_valid, out_ch, out_energy, out_full
    );
    modport slave (
`ifdef ENERGY_THRESH_EN
        input thresh, output out_above,
`endif
        input flush, in_valid, in_ch, in_sample,
        output out_valid, out_ch, out_energy, out_full
    );
endinterface

// File: rtl/windowed_energy_mc_delay_line.sv
// sample_delay_line: per-channel circular sample store; old is the sample this write retires,
// old_valid says the window was already full so old really leaves it.
module sample_delay_line
    import energy_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int WINDOW = 16,
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     we,
    input  logic [CH_W-1:0]          ch,
    input  logic signed [DATA_W-1:0] sample,
    output logic signed [DATA_W-1:0] old,
    output logic                     old_valid,
    output logic                     full
);
    localparam int WP_W   = clog2(WINDOW);
    localparam int FILL_W = clog2(WINDOW + 1);
    logic signed [DATA_W-1:0] mem [NUM_CH][WINDOW];
    logic [WP_W-1:0]          wp [NUM_CH];
    logic [FILL_W-1:0]        fill [NUM_CH];
    logic                     at_full;
    assign at_full = fill[ch] == FILL_W'(WINDOW);
    // RAM has no reset; fill counters hide whatever stale data it holds
    always_ff @(posedge clock) begin
        if (we) begin
            old <= mem[ch][wp[ch]];
            mem[ch][wp[ch]] <= sample;
        end
    end
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wp[c]   <= '0;
                fill[c] <= '0;
            end
            old_valid <= 1'b0;
            full      <= 1'b0;
        end else if (we) begin
            wp[ch]    <= (wp[ch] == WP_W'(WINDOW - 1)) ? '0 : wp[ch] + 1'b1;
            fill[ch]  <= at_full ? fill[ch] : fill[ch] + 1'b1;
            old_valid <= at_full;
            full      <= fill[ch] >= FILL_W'(WINDOW - 1);
        end
    end
endmodule

// File: rtl/windowed_energy_mc.sv
// windowed_energy_mc: per-channel sliding-window sum of squares, latency 2 from the accepting edge.
// ENERGY_THRESH_EN adds the thresh input and the out_above flag.
module windowed_energy_mc
    import energy_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int WINDOW = DEF_WINDOW,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = (clog2(NUM_CH) > 1) ? clog2(NUM_CH) : 1,
    parameter int ACC_W  = acc_w(DATA_W, WINDOW)
) (
    input logic                 clock,
    input logic                 reset,
    windowed_energy_mc_if.slave bus
);
    localparam int SQ_W = 2 * DATA_W;
    logic                     accept, s0_valid, s0_full, s1_valid, s1_full, old_valid;
    logic [CH_W-1:0]          s0_ch, s1_ch;
    logic signed [DATA_W-1:0] s0_new, old;
    logic signed [SQ_W-1:0]   new_x, old_x;
    logic [SQ_W-1:0]          sq_new, sq_old;
    logic [ACC_W-1:0]         acc [NUM_CH];
    logic [ACC_W-1:0]         acc_nxt;
    assign accept  = bus.in_valid && !bus.flush && 32'(bus.in_ch) < NUM_CH;
    assign new_x   = s0_new;
    assign old_x   = old;
    assign acc_nxt = acc[s1_ch] + ACC_W'(sq_new) - ACC_W'(sq_old);
    sample_delay_line #(.DATA_W(DATA_W), .WINDOW(WINDOW), .NUM_CH(NUM_CH), .CH_W(CH_W)) u_line (
        .clock     (clock),
        .reset     (reset),
        .flush     (bus.flush),
        .we        (accept),
        .ch        (bus.in_ch),
        .sample    (bus.in_sample),
        .old       (old),
        .old_valid (old_valid),
        .full      (s0_full)
    );
    // acc is written only here, so a same-channel follower one cycle later already sees the update
    always_ff @(posedge clock) begin
        if (!reset) begin
            s0_valid       <= 1'b0;
            s1_valid       <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_ch     <= '0;
            bus.out_energy <= '0;
            bus.out_full   <= 1'b0;
`ifdef ENERGY_THRESH_EN
            bus.out_above  <= 1'b0;
`endif
            for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
        end else if (bus.flush) begin
            s0_valid      <= 1'b0;
            s1_valid      <= 1'b0;
            bus.out_valid <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
        end else begin
            s0_valid      <= accept;
            s0_ch         <= bus.in_ch;
            s0_new        <= bus.in_sample;
            s1_valid      <= s0_valid;
            s1_ch         <= s0_ch;
            s1_full       <= s0_full;
            sq_new        <= new_x * new_x;
            sq_old        <= old_valid ? old_x * old_x : '0;
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                acc[s1_ch]     <= acc_nxt;
                bus.out_ch     <= s1_ch;
                bus.out_energy <= acc_nxt;
                bus.out_full   <= s1_full;
`ifdef ENERGY_THRESH_EN
                bus.out_above  <= s1_full && acc_nxt > bus.thresh;
`endif
            end
        end
    end
endmodule

// File: tb/tb_windowed_energy_mc.sv
// tb_windowed_energy_mc: scoreboard bench; a per-channel history queue model predicts every result.
module tb_windowed_energy_mc;
    localparam int DW = 16, W = 5, NC = 3, CW = 2, AW = 35;
    localparam longint THRESH = 125;
    typedef struct {
        longint due;
        int     ch;
        longint energy;
        bit     full;
        bit     above;
    } exp_t;
    logic clock = 1'b0;
    logic reset = 1'b0;
    longint cyc = 0;
    int checks = 0, passes = 0;
    exp_t exp_q[$];
    int hist[NC][$];
    windowed_energy_mc_if #(.DATA_W(DW), .CH_W(CW), .ACC_W(AW)) bus ();
    windowed_energy_mc #(.DATA_W(DW), .WINDOW(W), .NUM_CH(NC), .CH_W(CW), .ACC_W(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic int above_act();
`ifdef ENERGY_THRESH_EN
        return int'(bus.out_above);
`else
        return 0;
`endif
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_out_valid"}, longint'(bus.out_valid), 0);
        check({tag, "_out_ch"}, longint'(bus.out_ch), 0);
        check({tag, "_out_energy"}, longint'(bus.out_energy), 0);
        check({tag, "_out_full"}, longint'(bus.out_full), 0);
        check({tag, "_out_above"}, longint'(above_act()), 0);
    endtask

    // inputs change 1 time unit after an edge and are taken at the following edge (cyc+1)
    task automatic step(input bit v, input int ch, input int s, input bit fl, input bit rs);
        longint e;
        bit f;
        @(posedge clock);
        #1;
        reset         = !rs;
        bus.flush     = fl;
        bus.in_valid  = v;
        bus.in_ch     = ch[CW-1:0];
        bus.in_sample = s[DW-1:0];
        if (rs || fl) begin
            for (int c = 0; c < NC; c++) hist[c].delete();
            while (exp_q.size() > 0 && exp_q[$].due >= cyc + 1) void'(exp_q.pop_back());
        end else if (v && ch < NC) begin
            hist[ch].push_back(s);
            if (hist[ch].size() > W) void'(hist[ch].pop_front());
            e = 0;
            for (int i = 0; i < hist[ch].size(); i++) e += longint'(hist[ch][i]) * longint'(hist[ch][i]);
            f = hist[ch].size() == W;
`ifdef ENERGY_THRESH_EN
            exp_q.push_back('{cyc + 3, ch, e, f, f && e > THRESH});
`else
            exp_q.push_back('{cyc + 3, ch, e, f, 1'b0});
`endif
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (bus.out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_out: ch %0d energy %0d at cycle %0d, none expected",
                         bus.out_ch, bus.out_energy, cyc);
            end else begin
                e = exp_q.pop_front();
                if (int'(bus.out_ch) == e.ch && longint'(bus.out_energy) == e.energy &&
                    bus.out_full == e.full && above_act() == int'(e.above) && cyc == e.due)
                    passes++;
                else
                    $display("FAIL result: got ch %0d energy %0d full %0d above %0d cycle %0d; expected ch %0d energy %0d full %0d above %0d cycle %0d",
                             bus.out_ch, bus.out_energy, bus.out_full, above_act(), cyc,
                             e.ch, e.energy, e.full, e.above, e.due);
            end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            checks++;
            e = exp_q.pop_front();
            $display("FAIL missing_out: no out_valid at cycle %0d, expected ch %0d energy %0d", cyc, e.ch, e.energy);
        end
    end

    initial begin
        int ch, s;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_ch     = '0;
        bus.in_sample = '0;
`ifdef ENERGY_THRESH_EN
        bus.thresh    = AW'(THRESH);
`endif
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        check_zero("reset");
        for (int i = 1; i <= 7; i++) step(1, 0, i, 0, 0);
        repeat (6) step(1, 1, -32768, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, (i % 2) ? 2 : 0, (i % 2) ? -3 : 10, 0, 0);
            if (i % 5 == 4) step(1, 3, 999, 0, 0);
        end
        step(1, 0, 3, 0, 0);
        step(1, 2, 4, 0, 0);
        step(1, 0, 99, 1, 0);
        step(1, 0, 7, 0, 0);
        step(1, 0, 8, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        step(1, 0, 5, 0, 0);
        step(1, 1, 6, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        check_zero("midreset");
        repeat (3) step(0, 0, 0, 0, 0);
        repeat (5) step(1, 0, 5, 0, 0);
        step(1, 0, 6, 0, 0);
        for (int i = 0; i < 400; i++) begin
            ch = int'($urandom_range(0, 3));
            s = $urandom_range(0, 1) ? int'($urandom_range(0, 20)) - 10 : int'($urandom_range(0, 65535)) - 32768;
            step($urandom_range(0, 3) != 0, ch, s, $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0);
        end
        repeat (5) step(0, 0, 0, 0, 0);
        check("drain_pending", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
